// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter.
package mem_arbiter_pkg;

    // Requester indices used for grant vectors and muxing.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    // Default bound on consecutive locked grants while the other side waits.
    localparam int MAX_LOCK_DEF = 4;

    // Width of a counter that must hold values 0..max_lock inclusive.
    function automatic int lock_cnt_w(input int max_lock);
        return (max_lock < 1) ? 1 : $clog2(max_lock + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles both requester ports and the memory-side bus of the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    // Requester 0 (cpu)
    logic                  req0;
    logic                  we0;
    logic                  lock0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  gnt0;
    logic                  rvalid0;
    logic [DATA_WIDTH-1:0] rdata0;

    // Requester 1 (aux master)
    logic                  req1;
    logic                  we1;
    logic                  lock1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt1;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata1;

    // Memory side
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] mem_in;

    // Arbiter view.
    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        input  req1, we1, lock1, addr1, wdata1,
        input  mem_in,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_we, mem_addr, mem_data
    );

    // Requester/memory environment view.
    modport master (
        output req0, we0, lock0, addr0, wdata0,
        output req1, we1, lock1, addr1, wdata1,
        output mem_in,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_we, mem_addr, mem_data
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector with a lock override; purely combinational.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       lock_en,
    input  logic       lock_owner,
    output logic [1:0] gnt
);

    // One-hot grant: single request wins outright, a tie goes to the lock
    // owner while the lock is valid, otherwise to the side not served last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt[REQ_CPU] = 1'b1;
            2'b10: gnt[REQ_AUX] = 1'b1;
            2'b11: begin
                if (lock_en) begin
                    gnt[lock_owner] = 1'b1;
                end else begin
                    gnt[~last_gnt] = 1'b1;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port memory between the cpu and an aux
// master: same-cycle grants, round-robin fairness, bounded ownership lock,
// and a one-cycle read-return strobe per requester.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LOCK   = MAX_LOCK_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam int              LOCK_W   = lock_cnt_w(MAX_LOCK);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_LOCK);

    logic              last_gnt_q, last_gnt_d;
    logic              owner_q, owner_d;
    logic              owner_locked_q, owner_locked_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              rd_pend0_q, rd_pend0_d;
    logic              rd_pend1_q, rd_pend1_d;

    logic [1:0]            req_v;
    logic [1:0]            gnt;
    logic                  lock_en;
    logic                  mem_we_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_data_c;

    // Requests are masked while reset is asserted so grants drop at once;
    // the lock only overrides round-robin until its budget is spent.
    always_comb begin
        req_v   = {bus.req1 & rst_n, bus.req0 & rst_n};
        lock_en = owner_locked_q && (lock_cnt_q < LOCK_MAX);
    end

    rr_pick2 u_pick (
        .req        (req_v),
        .last_gnt   (last_gnt_q),
        .lock_en    (lock_en),
        .lock_owner (owner_q),
        .gnt        (gnt)
    );

    // Drive the memory from the granted requester; zeros when idle.
    always_comb begin
        mem_we_c   = 1'b0;
        mem_addr_c = '0;
        mem_data_c = '0;
        if (gnt[REQ_CPU]) begin
            mem_we_c   = bus.we0;
            mem_addr_c = bus.addr0;
            mem_data_c = bus.wdata0;
        end else if (gnt[REQ_AUX]) begin
            mem_we_c   = bus.we1;
            mem_addr_c = bus.addr1;
            mem_data_c = bus.wdata1;
        end
    end

    assign bus.gnt0     = gnt[REQ_CPU];
    assign bus.gnt1     = gnt[REQ_AUX];
    assign bus.mem_we   = mem_we_c;
    assign bus.mem_addr = mem_addr_c;
    assign bus.mem_data = mem_data_c;

    // Memory read data is valid the cycle after the address, so the return
    // strobe is just the registered "read granted" flag.
    assign bus.rvalid0 = rd_pend0_q;
    assign bus.rvalid1 = rd_pend1_q;
    assign bus.rdata0  = bus.mem_in;
    assign bus.rdata1  = bus.mem_in;

    // Next-state for fairness, lock bookkeeping and pending reads.
    always_comb begin
        logic              g_idx;
        logic              lock_g;
        logic              other_req;
        logic [LOCK_W-1:0] cnt_base;

        last_gnt_d     = last_gnt_q;
        owner_d        = owner_q;
        owner_locked_d = owner_locked_q;
        lock_cnt_d     = lock_cnt_q;
        rd_pend0_d     = 1'b0;
        rd_pend1_d     = 1'b0;
        g_idx          = gnt[REQ_AUX];
        lock_g         = g_idx ? bus.lock1 : bus.lock0;
        other_req      = g_idx ? req_v[REQ_CPU] : req_v[REQ_AUX];
        cnt_base       = '0;

        if (gnt != 2'b00) begin
            last_gnt_d = g_idx;
            rd_pend0_d = gnt[REQ_CPU] & ~bus.we0;
            rd_pend1_d = gnt[REQ_AUX] & ~bus.we1;
            if (lock_g) begin
                // A new owner starts its own budget; the current owner keeps
                // counting only the cycles where the other side was waiting.
                cnt_base       = (owner_locked_q && (owner_q == g_idx)) ? lock_cnt_q : '0;
                owner_d        = g_idx;
                owner_locked_d = 1'b1;
                if (other_req && (cnt_base != LOCK_MAX)) begin
                    lock_cnt_d = cnt_base + 1'b1;
                end else begin
                    lock_cnt_d = cnt_base;
                end
            end else begin
                owner_locked_d = 1'b0;
                lock_cnt_d     = '0;
            end
        end else begin
            owner_locked_d = 1'b0;
            lock_cnt_d     = '0;
        end
    end

    // State registers; last_gnt resets to 1 so the cpu wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q     <= 1'b1;
            owner_q        <= 1'b0;
            owner_locked_q <= 1'b0;
            lock_cnt_q     <= '0;
            rd_pend0_q     <= 1'b0;
            rd_pend1_q     <= 1'b0;
        end else begin
            last_gnt_q     <= last_gnt_d;
            owner_q        <= owner_d;
            owner_locked_q <= owner_locked_d;
            lock_cnt_q     <= lock_cnt_d;
            rd_pend0_q     <= rd_pend0_d;
            rd_pend1_q     <= rd_pend1_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_arbiter_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) bus ();

    mem_arbiter #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (16),
        .MAX_LOCK   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp0;
        checks = 0;
        errors = 0;
        rst_n       = 1'b0;
        bus.req0    = 1'b0; bus.we0 = 1'b0; bus.lock0 = 1'b0;
        bus.addr0   = '0;   bus.wdata0 = '0;
        bus.req1    = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0;
        bus.addr1   = '0;   bus.wdata1 = '0;
        bus.mem_in  = 16'h1234;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_gnt0",     bus.gnt0, 0);
        check("rst_gnt1",     bus.gnt1, 0);
        check("rst_rvalid0",  bus.rvalid0, 0);
        check("rst_rvalid1",  bus.rvalid1, 0);
        check("rst_mem_we",   bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_data", bus.mem_data, 0);
        check("rst_rdata0",   bus.rdata0, 16'h1234);
        rst_n = 1'b1;
        next_cycle();

        // Single cpu read at 0x08
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'h08;
        @(negedge clk);
        check("rd_gnt0",     bus.gnt0, 1);
        check("rd_gnt1",     bus.gnt1, 0);
        check("rd_mem_addr", bus.mem_addr, 6'h08);
        check("rd_mem_we",   bus.mem_we, 0);
        next_cycle();
        bus.req0 = 1'b0; bus.mem_in = 16'h7123;
        @(negedge clk);
        check("rd_rvalid0", bus.rvalid0, 1);
        check("rd_rdata0",  bus.rdata0, 16'h7123);
        check("rd_rvalid1", bus.rvalid1, 0);
        next_cycle();

        // Aux write 0xBEEF to 0x05
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 6'h05; bus.wdata1 = 16'hBEEF;
        @(negedge clk);
        check("wr_gnt1",     bus.gnt1, 1);
        check("wr_gnt0",     bus.gnt0, 0);
        check("wr_mem_we",   bus.mem_we, 1);
        check("wr_mem_addr", bus.mem_addr, 6'h05);
        check("wr_mem_data", bus.mem_data, 16'hBEEF);
        next_cycle();
        bus.req1 = 1'b0; bus.we1 = 1'b0;
        @(negedge clk);
        check("wr_no_rvalid1", bus.rvalid1, 0);
        check("idle_mem_we",   bus.mem_we, 0);
        check("idle_mem_addr", bus.mem_addr, 0);
        check("idle_mem_data", bus.mem_data, 0);
        next_cycle();

        // Round-robin: both reading, no locks; last winner was aux
        bus.req0 = 1'b1; bus.addr0 = 6'h01;
        bus.req1 = 1'b1; bus.addr1 = 6'h02;
        for (int k = 0; k < 4; k++) begin
            exp0 = ((k % 2) == 0);
            @(negedge clk);
            check("rr_gnt0",     bus.gnt0, exp0);
            check("rr_gnt1",     bus.gnt1, !exp0);
            check("rr_mem_addr", bus.mem_addr, exp0 ? 6'h01 : 6'h02);
            if (k > 0) check("rr_rvalid0", bus.rvalid0, !exp0);
            next_cycle();
        end

        // Contested lock: cpu holds lock0, aux waits; 4 cpu grants then aux
        bus.lock0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("lk_gnt0", bus.gnt0, (k < 4));
            check("lk_gnt1", bus.gnt1, (k == 4));
            next_cycle();
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock0 = 1'b0;
        @(negedge clk);
        check("lk_rvalid1", bus.rvalid1, 1);
        check("lk_idle_gnt0", bus.gnt0, 0);
        next_cycle();

        // Uncontested lock: counter must not advance
        bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.we0 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("ul_gnt0", bus.gnt0, 1);
            check("ul_cnt",  dut.lock_cnt_q, 0);
            next_cycle();
        end
        bus.req1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("ul2_gnt0", bus.gnt0, (k < 4));
            check("ul2_gnt1", bus.gnt1, (k == 4));
            check("ul2_cnt",  dut.lock_cnt_q, k);
            next_cycle();
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock0 = 1'b0; bus.we0 = 1'b0;
        next_cycle();

        // Reset in the middle of a granted read
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'h2A;
        @(negedge clk);
        check("mr_gnt0",     bus.gnt0, 1);
        check("mr_mem_addr", bus.mem_addr, 6'h2A);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_rst_gnt0",     bus.gnt0, 0);
        check("mr_rst_mem_we",   bus.mem_we, 0);
        check("mr_rst_mem_addr", bus.mem_addr, 0);
        @(negedge clk);
        check("mr_rst_rvalid0", bus.rvalid0, 0);
        rst_n = 1'b1;
        bus.req1 = 1'b1;
        #1;
        check("mr_tie_gnt0", bus.gnt0, 1);
        check("mr_tie_gnt1", bus.gnt1, 0);
        next_cycle();
        @(negedge clk);
        check("mr_rr_gnt1", bus.gnt1, 1);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
